pulpemu_clk_div_bank: RTL and testbench

Multi-channel, runtime-reconfigurable clock/strobe divider for the FPGA emulation top.
- Generalises the fixed single-DIVISOR ref-clock divider and LED heartbeat divider.
- Provides N_CH independent divided outputs from one fabric clock: 32768 Hz ref clock, 1 Hz LED blink, peripheral ticks.
- Divisor, enable and mode are updated per channel through a valid/ready config port.
- Updates take effect glitch-free at period boundaries.

---
 rtl/pulpemu_clk_div_pkg.sv | 34 +++
 rtl/pulpemu_clk_div_ch.sv | 112 +++++++++++
 rtl/pulpemu_clk_div_bank.sv | 90 +++++++++
 tb/tb_pulpemu_clk_div_bank.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulpemu_clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pulpemu_clk_div_pkg
// Purpose  : Shared types and helpers for the multi-channel clock/strobe
//            divider bank (mode encoding, channel config record, channel
//            index width helper).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pulpemu_clk_div_pkg;

  // Output shape of one channel: 50% square wave, or strobe-only.
  typedef enum logic {
    SQUARE = 1'b0,
    PULSE  = 1'b1
  } clk_div_mode_e;

  // Default divisor width; the RTL itself is parametrised on DIV_W.
  localparam int unsigned c_div_w_def = 16;

  // Per-channel configuration record at the default divisor width.
  typedef struct packed {
    logic [c_div_w_def-1:0] div;
    logic                   en;
    clk_div_mode_e          mode;
  } ch_cfg_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pulpemu_clk_div_ch.sv
`default_nettype none
// ============================================================================
// Module   : pulpemu_clk_div_ch
// Purpose  : One divider channel: counter, registered clk/tick outputs,
//            shadow configuration and the period-boundary apply logic.
// Ports    : i_clk     - fabric clock
//            i_rstn    - synchronous active-low reset
//            i_load    - stage {i_div, i_en, i_mode} into the shadow register
//            i_div     - staged divisor
//            i_en      - staged enable
//            i_mode    - staged mode
//            o_clk     - divided square output (registered)
//            o_tick    - one-cycle terminal-count strobe (registered)
//            o_pending - staged update not yet applied
// Revision : 1.0 - initial release
// ============================================================================
module pulpemu_clk_div_ch
  import pulpemu_clk_div_pkg::*;
#(
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned RST_DIV  = 256,
  parameter bit          RST_EN   = 1'b1,
  parameter bit          RST_MODE = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_en,
  input  clk_div_mode_e    i_mode,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_pending
);

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic             en;
    clk_div_mode_e    mode;
  } cfg_t;

  localparam logic [DIV_W-1:0] c_one     = DIV_W'(1);
  localparam cfg_t             c_rst_cfg = '{
    div:  DIV_W'(RST_DIV),
    en:   RST_EN,
    mode: (RST_MODE ? PULSE : SQUARE)
  };

  cfg_t             r_cfg;
  cfg_t             r_shadow;
  logic [DIV_W-1:0] r_cnt;
  logic             r_clk;
  logic             r_tick;
  logic             r_pending;

  logic w_active;
  logic w_terminal;
  logic w_apply;

  // A zero divisor counts as disabled so the terminal compare never wraps.
  assign w_active   = r_cfg.en && (r_cfg.div != '0);
  assign w_terminal = w_active && (r_cnt == (r_cfg.div - c_one));

  // Disabled channels take a staged update immediately. Running channels
  // wait for a period boundary; in SQUARE mode only the terminal that
  // drives clk 1->0 qualifies, so a high phase is never cut short.
  assign w_apply = r_pending &&
                   (!w_active ||
                    (w_terminal && ((r_cfg.mode == PULSE) || r_clk)));

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cfg     <= c_rst_cfg;
      r_shadow  <= c_rst_cfg;
      r_cnt     <= '0;
      r_clk     <= 1'b0;
      r_tick    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      if (w_terminal) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
        r_clk  <= (r_cfg.mode == SQUARE) ? ~r_clk : 1'b0;
      end else if (w_active) begin
        r_cnt  <= r_cnt + c_one;
        r_tick <= 1'b0;
      end else begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
        r_clk  <= 1'b0;
      end

      // The terminal tick above is kept on the apply cycle; only the
      // counter and clk restart from a clean low phase.
      if (w_apply) begin
        r_cfg     <= r_shadow;
        r_pending <= 1'b0;
        r_cnt     <= '0;
        r_clk     <= 1'b0;
      end else if (i_load) begin
        r_shadow  <= '{div: i_div, en: i_en, mode: i_mode};
        r_pending <= 1'b1;
      end
    end
  end

  assign o_clk     = r_clk;
  assign o_tick    = r_tick;
  assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/pulpemu_clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : pulpemu_clk_div_bank
// Purpose  : N_CH independent runtime-reconfigurable clock/strobe dividers
//            sharing one valid/ready configuration port.
// Ports    : clk_i       - fabric clock
//            rstn_i      - synchronous active-low reset
//            cfg_valid_i - config request valid
//            cfg_ready_o - config accepted when cfg_valid_i is also high
//            cfg_ch_i    - target channel (out-of-range requests are dropped)
//            cfg_div_i   - new divisor
//            cfg_en_i    - new enable
//            cfg_mode_i  - new mode (0 = SQUARE, 1 = PULSE)
//            clk_o       - divided square outputs
//            tick_o      - terminal-count strobes
//            pending_o   - per-channel staged-update flags
// Revision : 1.0 - initial release
// ============================================================================
module pulpemu_clk_div_bank
  import pulpemu_clk_div_pkg::*;
#(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned RST_DIV  = 256,
  parameter int unsigned RST_EN   = 1,
  parameter int unsigned RST_MODE = 0
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        cfg_valid_i,
  output logic                        cfg_ready_o,
  input  logic [ch_idx_w(N_CH)-1:0]   cfg_ch_i,
  input  logic [DIV_W-1:0]            cfg_div_i,
  input  logic                        cfg_en_i,
  input  logic                        cfg_mode_i,
  output logic [N_CH-1:0]             clk_o,
  output logic [N_CH-1:0]             tick_o,
  output logic [N_CH-1:0]             pending_o
);

  localparam int unsigned       c_ch_w = ch_idx_w(N_CH);
  localparam int unsigned       c_pad  = 1 << c_ch_w;
  localparam logic [c_ch_w:0]   c_n_ch = (c_ch_w + 1)'(N_CH);

  logic [c_pad-1:0] w_pend_pad;
  logic [N_CH-1:0]  w_load;
  logic             w_in_range;

  // Compare one bit wider than the index so N_CH == 2**c_ch_w still works.
  assign w_in_range = ({1'b0, cfg_ch_i} < c_n_ch);

  // Pad pending flags to the full index space so the ready mux never
  // selects past the end of the vector.
  for (genvar g = 0; g < c_pad; g++) begin : g_pad
    if (g < N_CH) begin : g_real
      assign w_pend_pad[g] = pending_o[g];
    end else begin : g_none
      assign w_pend_pad[g] = 1'b0;
    end
  end

  // Out-of-range requests are acknowledged and silently discarded.
  assign cfg_ready_o = !w_in_range || !w_pend_pad[cfg_ch_i];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    localparam logic [c_ch_w-1:0] c_idx = c_ch_w'(g);

    assign w_load[g] = cfg_valid_i && w_in_range && !pending_o[g] &&
                       (cfg_ch_i == c_idx);

    pulpemu_clk_div_ch #(
      .DIV_W    (DIV_W),
      .RST_DIV  (RST_DIV),
      .RST_EN   (RST_EN != 0),
      .RST_MODE (RST_MODE != 0)
    ) u_ch (
      .i_clk     (clk_i),
      .i_rstn    (rstn_i),
      .i_load    (w_load[g]),
      .i_div     (cfg_div_i),
      .i_en      (cfg_en_i),
      .i_mode    (clk_div_mode_e'(cfg_mode_i)),
      .o_clk     (clk_o[g]),
      .o_tick    (tick_o[g]),
      .o_pending (pending_o[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_pulpemu_clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulpemu_clk_div_bank
// Purpose  : Self-checking bench for pulpemu_clk_div_bank. Three channels so
//            that an out-of-range channel index exists. Expected outputs come
//            from a closed-form schedule model: each channel remembers the
//            cycle its counter started, and outputs follow from the elapsed
//            cycle count divided by the divisor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulpemu_clk_div_bank;

  localparam int N_CH    = 3;
  localparam int DIV_W   = 16;
  localparam int RST_DIV = 256;
  localparam int CH_W    = 2;

  logic             clk = 1'b0;
  logic             rstn;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_en;
  logic             cfg_mode;
  logic [N_CH-1:0]  clk_o;
  logic [N_CH-1:0]  tick_o;
  logic [N_CH-1:0]  pending_o;

  always #5 clk = ~clk;

  pulpemu_clk_div_bank #(
    .N_CH     (N_CH),
    .DIV_W    (DIV_W),
    .RST_DIV  (RST_DIV),
    .RST_EN   (1),
    .RST_MODE (0)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_ch_i    (cfg_ch),
    .cfg_div_i   (cfg_div),
    .cfg_en_i    (cfg_en),
    .cfg_mode_i  (cfg_mode),
    .clk_o       (clk_o),
    .tick_o      (tick_o),
    .pending_o   (pending_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit m_init   = 0;

  // Reference model state, sized to the full index space.
  int m_s    [4];   // cycle at which the counter last restarted
  int m_div  [4];
  bit m_en   [4];
  bit m_mode [4];   // 1 = PULSE
  bit m_p    [4];
  int m_at   [4];   // cycle at which the staged update lands
  int m_sdiv [4];
  bit m_sen  [4];
  bit m_smode[4];
  logic [N_CH-1:0] m_clk, m_tick, m_pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    if (int'(cfg_ch) >= N_CH) return 1'b1;
    return !m_p[cfg_ch];
  endfunction

  // Advance the model across one rising edge using the inputs held there.
  task automatic model_edge();
    bit rdy;
    int n, k, ch;
    if (!rstn) begin
      for (int i = 0; i < N_CH; i++) begin
        m_s[i] = cyc; m_div[i] = RST_DIV; m_en[i] = 1'b1; m_mode[i] = 1'b0;
        m_p[i] = 1'b0; m_clk[i] = 1'b0; m_tick[i] = 1'b0;
      end
      m_init = 1'b1;
    end else begin
      rdy = model_ready();
      for (int i = 0; i < N_CH; i++) begin
        if (m_en[i] && m_div[i] != 0) begin
          n = cyc - m_s[i];
          m_tick[i] = (n > 0) && (n % m_div[i] == 0);
          m_clk[i]  = !m_mode[i] && ((n / m_div[i]) % 2 == 1);
        end else begin
          m_tick[i] = 1'b0;
          m_clk[i]  = 1'b0;
        end
        if (m_p[i] && cyc == m_at[i]) begin
          m_div[i] = m_sdiv[i]; m_en[i] = m_sen[i]; m_mode[i] = m_smode[i];
          m_s[i] = cyc; m_p[i] = 1'b0; m_clk[i] = 1'b0;
        end
      end
      if (cfg_valid && rdy && int'(cfg_ch) < N_CH) begin
        ch = int'(cfg_ch);
        m_sdiv[ch] = int'(cfg_div); m_sen[ch] = cfg_en; m_smode[ch] = cfg_mode;
        m_p[ch] = 1'b1;
        if (!(m_en[ch] && m_div[ch] != 0)) begin
          m_at[ch] = cyc + 1;
        end else begin
          // Next terminal strictly after now; SQUARE needs an even count
          // of half-periods so the output is falling there.
          k = (cyc - m_s[ch]) / m_div[ch] + 1;
          if (!m_mode[ch] && (k % 2 == 1)) k++;
          m_at[ch] = m_s[ch] + k * m_div[ch];
        end
      end
    end
    for (int i = 0; i < N_CH; i++) m_pend[i] = m_p[i];
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check("clk_o", 32'(clk_o), 32'(m_clk));
    check("tick_o", 32'(tick_o), 32'(m_tick));
    check("pending_o", 32'(pending_o), 32'(m_pend));
  endtask

  task automatic drive(input bit v, input int ch, input int dv, input bit en,
                       input bit md, input bit rn);
    cfg_valid = v;
    cfg_ch    = CH_W'(ch);
    cfg_div   = DIV_W'(dv);
    cfg_en    = en;
    cfg_mode  = md;
    rstn      = rn;
    #1;
    if (m_init) check("cfg_ready_o", 32'(cfg_ready), 32'(model_ready()));
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic cfg_write(input int ch, input int dv, input bit en, input bit md);
    bit done = 1'b0;
    for (int t = 0; t < 2000 && !done; t++) begin
      drive(1'b1, ch, dv, en, md, 1'b1);
      done = model_ready();
      step();
    end
    idle();
    check("cfg_accept", 32'(done), 32'd1);
  endtask

  task automatic wait_clear(input int ch);
    bit done = 1'b0;
    for (int t = 0; t < 2000 && !done; t++) begin
      if (pending_o[ch] == 1'b0) done = 1'b1;
      else step();
    end
    check("pending_clear", 32'(done), 32'd1);
  endtask

  initial begin
    int   cnt, hi, lo, ticks, seen, tog, r, dv;
    logic prev;

    // Reset state
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    check("rst_clk", 32'(clk_o), 32'd0);
    check("rst_tick", 32'(tick_o), 32'd0);
    check("rst_pend", 32'(pending_o), 32'd0);
    idle();

    // Default divisor: first rise 256 cycles after reset release
    cnt = 0;
    while (clk_o[0] !== 1'b1 && cnt < 1000) begin step(); cnt++; end
    check("first_rise", 32'(cnt), 32'd256);

    // Reprogram ch0 to div=4 while high: high phase must stay full length
    drive(1'b1, 0, 4, 1'b1, 1'b0, 1'b1);
    hi = 1;
    for (int t = 0; t < 2000; t++) begin
      step();
      if (t == 0) idle();
      if (clk_o[0] !== 1'b1) break;
      hi++;
    end
    check("hi_phase_256", 32'(hi), 32'd256);
    lo = 1;
    for (int t = 0; t < 100; t++) begin step(); if (clk_o[0] !== 1'b0) break; lo++; end
    check("lo_phase_div4", 32'(lo), 32'd4);
    hi = 1;
    for (int t = 0; t < 100; t++) begin step(); if (clk_o[0] !== 1'b1) break; hi++; end
    check("hi_phase_div4", 32'(hi), 32'd4);

    // ch1: disable, then div=3 PULSE applies the cycle after transfer
    cfg_write(1, 0, 1'b1, 1'b1);
    wait_clear(1);
    cfg_write(1, 3, 1'b1, 1'b1);
    check("pend1_set", 32'(pending_o[1]), 32'd1);
    step();
    check("pend1_clr", 32'(pending_o[1]), 32'd0);
    ticks = 0; seen = 0;
    repeat (30) begin step(); ticks += int'(tick_o[1]); seen += int'(clk_o[1]); end
    check("ch1_ticks", 32'(ticks), 32'd10);
    check("ch1_clk_low", 32'(seen), 32'd0);

    // ch0: div=0 disables, then div=1 SQUARE gives clk/2
    cfg_write(0, 0, 1'b1, 1'b0);
    wait_clear(0);
    ticks = 0; seen = 0;
    repeat (20) begin step(); ticks += int'(tick_o[0]); seen += int'(clk_o[0]); end
    check("div0_tick", 32'(ticks), 32'd0);
    check("div0_clk", 32'(seen), 32'd0);
    cfg_write(0, 1, 1'b1, 1'b0);
    step();
    check("pend0_clr", 32'(pending_o[0]), 32'd0);
    prev = clk_o[0]; tog = 0; ticks = 0;
    repeat (10) begin
      step();
      tog += (clk_o[0] != prev) ? 1 : 0;
      prev = clk_o[0];
      ticks += int'(tick_o[0]);
    end
    check("div1_toggles", 32'(tog), 32'd10);
    check("div1_ticks", 32'(ticks), 32'd10);

    // Back-to-back writes, other-channel write, out-of-range drop
    cfg_write(0, 5, 1'b1, 1'b0);
    drive(1'b1, 0, 2, 1'b1, 1'b0, 1'b1);
    check("b2b_stall", 32'(cfg_ready), 32'd0);
    drive(1'b1, 1, 6, 1'b1, 1'b0, 1'b1);
    check("other_ch_ready", 32'(cfg_ready), 32'd1);
    step();
    drive(1'b1, 3, 9, 1'b1, 1'b1, 1'b1);
    check("drop_ready", 32'(cfg_ready), 32'd1);
    step();
    check("drop_no_pend2", 32'(pending_o[2]), 32'd0);
    cfg_write(0, 2, 1'b1, 1'b0);
    repeat (40) step();

    // Reset while an update is staged
    cfg_write(2, 7, 1'b1, 1'b1);
    check("pend2_set", 32'(pending_o[2]), 32'd1);
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    check("rst_pend_clr", 32'(pending_o), 32'd0);
    cnt = 0;
    while (clk_o[0] !== 1'b1 && cnt < 1000) begin step(); cnt++; end
    check("rise_after_rst", 32'(cnt), 32'd256);

    // Randomised traffic against the model
    for (int t = 0; t < 3000; t++) begin
      r  = $urandom_range(0, 19);
      dv = (r == 0) ? 0 : (r == 1) ? $urandom_range(1, 65535) : $urandom_range(1, 12);
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 3), dv,
            $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 499) != 0);
      step();
    end
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
